vga_frame_sequencer: RTL and testbench



---
 rtl/vga_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_vga_frame_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_sequencer.sv
// SVGA raster timing plus a frame-synchronous configuration register.
// All outputs are registered and decoded from the next counter values, so they line up with hpos/vpos.
module vga_frame_sequencer #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1,
  parameter int CFG_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] cfg_active,
  output logic             cfg_applied,
  output logic [10:0]      hpos,
  output logic [9:0]       vpos,
  output logic             display_en,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_IDLE, S_PENDING} cfg_state_t;

  logic [10:0]      r_hpos;
  logic [9:0]       r_vpos;
  logic             r_display_en;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_line_start;
  logic             r_frame_start;
  cfg_state_t       r_state;
  logic [CFG_W-1:0] r_shadow;
  logic [CFG_W-1:0] r_cfg_active;
  logic             r_cfg_applied;
  logic             r_cfg_ready;

  logic             w_hwrap;
  logic             w_frame_wrap;
  logic [10:0]      w_hpos_next;
  logic [9:0]       w_vpos_next;
  cfg_state_t       w_state_next;
  logic             w_capture;
  logic             w_apply;

  assign w_hwrap      = (r_hpos == H_LAST);
  assign w_frame_wrap = w_hwrap && (r_vpos == V_LAST);
  assign w_hpos_next  = w_hwrap ? 11'd0 : r_hpos + 11'd1;
  assign w_vpos_next  = w_frame_wrap ? 10'd0 : (w_hwrap ? r_vpos + 10'd1 : r_vpos);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_display_en  <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hpos        <= w_hpos_next;
      r_vpos        <= w_vpos_next;
      r_display_en  <= (w_hpos_next < H_VIS) && (w_vpos_next < V_VIS);
      r_hsync       <= ((w_hpos_next >= H_SYNC_BEG) && (w_hpos_next < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= ((w_vpos_next >= V_SYNC_BEG) && (w_vpos_next < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      r_line_start  <= (w_hpos_next == 11'd0) && (w_vpos_next < V_VIS);
      r_frame_start <= (w_hpos_next == 11'd0) && (w_vpos_next == 10'd0);
    end
  end

  // A word captured on the boundary edge itself lands in PENDING and waits a full frame.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_valid) begin
          w_capture    = 1'b1;
          w_state_next = S_PENDING;
        end
      end
      S_PENDING: begin
        if (w_frame_wrap) begin
          w_apply      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shadow      <= '0;
      r_cfg_active  <= '0;
      r_cfg_applied <= 1'b0;
      r_cfg_ready   <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_cfg_applied <= w_apply;
      r_cfg_ready   <= (w_state_next == S_IDLE);
      if (w_capture) begin
        r_shadow <= cfg_data;
      end
      if (w_apply) begin
        r_cfg_active <= r_shadow;
      end
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign display_en  = r_display_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign cfg_ready   = r_cfg_ready;
  assign cfg_active  = r_cfg_active;
  assign cfg_applied = r_cfg_applied;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer on a shrunken raster (15x10 totals, 150-cycle frame).
// Timing constants below are worked out by hand from the reduced parameters.
module tb_vga_frame_sequencer;

  // Reduced raster: H 8+2+3+2=15, V 5+1+2+2=10
  localparam int FRAME   = 150;
  localparam int DE_CNT  = 40;   // 8 px * 5 lines
  localparam int LS_CNT  = 5;
  localparam int HS_CNT  = 30;   // 3 px * 10 lines
  localparam int VS_CNT  = 30;   // 2 lines * 15 px

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        cfg_ready;
  logic [15:0] cfg_active;
  logic        cfg_applied;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic        display_en, hsync, vsync, line_start, frame_start;

  int n_total = 0;
  int n_bad   = 0;

  vga_frame_sequencer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .CFG_W(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_active(cfg_active), .cfg_applied(cfg_applied),
    .hpos(hpos), .vpos(vpos), .display_en(display_en), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_hpos"}, 32'(hpos), 0);
    check_eq({tag, "_vpos"}, 32'(vpos), 0);
    check_eq({tag, "_de"}, 32'(display_en), 0);
    check_eq({tag, "_hs"}, 32'(hsync), 0);
    check_eq({tag, "_vs"}, 32'(vsync), 0);
    check_eq({tag, "_ls"}, 32'(line_start), 0);
    check_eq({tag, "_fs"}, 32'(frame_start), 0);
    check_eq({tag, "_act"}, 32'(cfg_active), 0);
    check_eq({tag, "_appl"}, 32'(cfg_applied), 0);
    check_eq({tag, "_rdy"}, 32'(cfg_ready), 1);
  endtask

  // Steps until cfg_applied; cfg_active must hold old_val and cfg_ready stay low until then.
  task automatic run_to_apply(input string tag, input logic [15:0] old_val,
                              input logic [15:0] new_val, output int cycles);
    int early = 0;
    int rdy = 0;
    cycles = 0;
    while (!cfg_applied && cycles < 3 * FRAME) begin
      if (cfg_active != old_val) early++;
      if (cfg_ready) rdy++;
      step();
      cycles++;
    end
    check_eq({tag, "_seen"}, 32'(cfg_applied), 1);
    check_eq({tag, "_early"}, 32'(early), 0);
    check_eq({tag, "_rdy_low"}, 32'(rdy), 0);
    check_eq({tag, "_fs"}, 32'(frame_start), 1);
    check_eq({tag, "_val"}, 32'(cfg_active), 32'(new_val));
    $display("apply %s: active=%h after %0d cycles at (%0d,%0d)", tag, cfg_active, cycles, hpos, vpos);
  endtask

  task automatic wait_pos(input string tag, input int h, input int v);
    int n = 0;
    while (!(int'(hpos) == h && int'(vpos) == v) && n < 2 * FRAME) begin
      step();
      n++;
    end
    check_eq({tag, "_reach"}, 32'(int'(hpos) == h && int'(vpos) == v), 1);
  endtask

  initial begin
    int n;
    int de_c, ls_c, fs_c, hs_c, vs_c, pos_err, de_bad, hs_bad, vs_bad, ls_bad;
    int cyc, appl_c, act_bad;

    // Reset
    repeat (3) step();
    check_reset_state("rst");
    rst = 1'b0;
    step();
    check_eq("first_hpos", 32'(hpos), 1);
    check_eq("first_vpos", 32'(vpos), 0);
    check_eq("first_de", 32'(display_en), 1);
    check_eq("first_fs", 32'(frame_start), 0);

    // First frame_start arrives after 149 edges, since pixel (0,0) is skipped
    n = 0;
    while (!frame_start && n < 2 * FRAME) begin
      step();
      n++;
    end
    check_eq("first_fs_dist", 32'(n), FRAME - 1);

    // Two full frames of raster statistics
    for (int f = 0; f < 2; f++) begin
      de_c = 0; ls_c = 0; fs_c = 0; hs_c = 0; vs_c = 0;
      pos_err = 0; de_bad = 0; hs_bad = 0; vs_bad = 0; ls_bad = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (int'(hpos) != i % 15 || int'(vpos) != i / 15) pos_err++;
        if (display_en) de_c++;
        if (line_start) ls_c++;
        if (frame_start) fs_c++;
        if (hsync) hs_c++;
        if (vsync) vs_c++;
        if (display_en && (hpos >= 8 || vpos >= 5)) de_bad++;
        if (hsync != (hpos >= 10 && hpos <= 12)) hs_bad++;
        if (vsync != (vpos >= 6 && vpos <= 7)) vs_bad++;
        if (line_start && hpos != 0) ls_bad++;
        step();
      end
      check_eq("frm_pos", 32'(pos_err), 0);
      check_eq("frm_de_cnt", 32'(de_c), DE_CNT);
      check_eq("frm_ls_cnt", 32'(ls_c), LS_CNT);
      check_eq("frm_fs_cnt", 32'(fs_c), 1);
      check_eq("frm_hs_cnt", 32'(hs_c), HS_CNT);
      check_eq("frm_vs_cnt", 32'(vs_c), VS_CNT);
      check_eq("frm_de_range", 32'(de_bad), 0);
      check_eq("frm_hs_range", 32'(hs_bad), 0);
      check_eq("frm_vs_range", 32'(vs_bad), 0);
      check_eq("frm_ls_range", 32'(ls_bad), 0);
      check_eq("frm_fs_period", 32'(frame_start), 1);
      $display("frame %0d: de=%0d ls=%0d hs=%0d vs=%0d", f, de_c, ls_c, hs_c, vs_c);
    end

    // Mid-frame word 0x1234
    repeat (40) step();
    cfg_data = 16'h1234;
    cfg_valid = 1'b1;
    step();
    check_eq("w1234_accept", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    $display("accept 1234 at (%0d,%0d)", hpos, vpos);
    run_to_apply("w1234", 16'h0000, 16'h1234, cyc);
    step();
    check_eq("w1234_ready_back", 32'(cfg_ready), 1);
    check_eq("w1234_pulse_1cyc", 32'(cfg_applied), 0);

    // 0xAAAA then 0x5555 held: 0x5555 waits for the boundary that applies 0xAAAA
    repeat (20) step();
    cfg_data = 16'hAAAA;
    cfg_valid = 1'b1;
    step();
    check_eq("wAAAA_accept", 32'(cfg_ready), 0);
    cfg_data = 16'h5555;
    run_to_apply("wAAAA", 16'h1234, 16'hAAAA, cyc);
    check_eq("w5555_not_yet", 32'(cfg_ready), 1);
    step();
    check_eq("w5555_accept", 32'(cfg_ready), 0);
    check_eq("w5555_hold_act", 32'(cfg_active), 32'(16'hAAAA));
    cfg_valid = 1'b0;
    run_to_apply("w5555", 16'hAAAA, 16'h5555, cyc);
    check_eq("w5555_one_frame", 32'(cyc), FRAME - 1);

    // Word offered on the boundary edge: skipped at that frame_start, applied at the next
    wait_pos("beef", 14, 9);
    cfg_data = 16'hBEEF;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check_eq("beef_fs", 32'(frame_start), 1);
    check_eq("beef_no_appl", 32'(cfg_applied), 0);
    check_eq("beef_accept", 32'(cfg_ready), 0);
    run_to_apply("wBEEF", 16'h5555, 16'hBEEF, cyc);
    check_eq("beef_next_frame", 32'(cyc), FRAME);

    // Reset while a word is pending
    cfg_data = 16'h7777;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check_eq("w7777_accept", 32'(cfg_ready), 0);
    wait_pos("rst_mid", 5, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst_mid");
    step();
    check_eq("rst_mid_hpos", 32'(hpos), 1);
    check_eq("rst_mid_vpos", 32'(vpos), 0);
    appl_c = 0;
    act_bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (cfg_applied) appl_c++;
      if (cfg_active != 16'h0000) act_bad++;
      step();
    end
    check_eq("rst_mid_no_appl", 32'(appl_c), 0);
    check_eq("rst_mid_act_zero", 32'(act_bad), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
